// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, multiplier FSM states
// and the EX/MEM control payload.
package ex_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned MULT_ITER = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_MULTU = 4'b1000,
    ALU_MFHI  = 4'b1001,
    ALU_MFLO  = 4'b1010,
    ALU_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_BUSY = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  // Control bits carried through EX/MEM
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per BUSY cycle.
// The product is held until the next start so it can be committed on DONE exit.
module mult_unit import ex_pkg::*; #(
  parameter int unsigned MULT_ITER = ex_pkg::MULT_ITER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [XLEN-1:0]     mcand,
  input  logic [XLEN-1:0]     mplier,
  output logic                idle_c,
  output logic                busy_c,
  output logic                done_c,
  output logic [2*XLEN-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(MULT_ITER + 1);

  mult_state_e      state_q;
  mult_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mcand_q;
  logic             last_step_c;
  logic [XLEN:0]    sum_c;

  assign last_step_c = (cnt_q == CNT_W'(MULT_ITER - 1));

  // Upper half plus multiplicand, keeping the carry for the right shift
  assign sum_c = {1'b0, product[2*XLEN-1:XLEN]} + (product[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MULT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_c  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      MULT_IDLE: begin
        idle_c = 1'b1;
        if (start) begin
          state_d = MULT_BUSY;
        end
      end
      MULT_BUSY: begin
        busy_c = 1'b1;
        if (abort) begin
          state_d = MULT_IDLE;
        end else if (last_step_c) begin
          state_d = MULT_DONE;
        end
      end
      MULT_DONE: begin
        done_c  = 1'b1;
        state_d = MULT_IDLE;
      end
      default: state_d = MULT_IDLE;
    endcase
  end

  // Lower half starts as the multiplier and is consumed LSB-first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      product <= '0;
    end else if (idle_c && start) begin
      cnt_q   <= '0;
      mcand_q <= mcand;
      product <= {{XLEN{1'b0}}, mplier};
    end else if (busy_c && !abort) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      product <= {sum_c, product[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, operand/destination muxes, HI/LO, EX/MEM register and the
// pipeline stall raised while MULTU iterates.
module ex_stage import ex_pkg::*; #(
  parameter int unsigned MULT_ITER = ex_pkg::MULT_ITER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [XLEN-1:0]     rs_data,
  input  logic [XLEN-1:0]     rt_data,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     pc_plus4,
  input  logic [REG_AW-1:0]   rt_addr,
  input  logic [REG_AW-1:0]   rd_addr,
  input  logic [ALU_OP_W-1:0] aluCtrl,
  input  logic                ALUSrc,
  input  logic                RegDst,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic                branch,
  input  logic                regWriteIn,
  input  logic                MemToRegIn,
  input  logic                flush,
  output logic                stall,
  output logic [XLEN-1:0]     ALUresult,
  output logic [XLEN-1:0]     Rt_data,
  output logic [XLEN-1:0]     branch_out,
  output logic                zero,
  output logic                memReadOut,
  output logic                memWriteOut,
  output logic                branchOut,
  output logic                regWriteOut,
  output logic                MemToRegOut,
  output logic [REG_AW-1:0]   Destination_out
);

  logic [XLEN-1:0]   opb_c;
  logic [XLEN-1:0]   alu_res_c;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [2*XLEN-1:0] mult_product;
  logic              is_multu_c;
  logic              mult_start_c;
  logic              mult_idle_c;
  logic              mult_busy_c;
  logic              mult_done_c;
  logic              bubble_c;
  ex_ctrl_t          ctrl_in_c;
  ex_ctrl_t          ctrl_q;

  assign opb_c        = ALUSrc ? imm : rt_data;
  assign is_multu_c   = (aluCtrl == ALU_MULTU);
  assign mult_start_c = valid_in & is_multu_c & ~flush;

  // Stall covers the issue cycle and every BUSY cycle; forced low during reset
  assign stall = rst & ((mult_start_c & mult_idle_c) | mult_busy_c);

  // MULTU never writes the register file, so it always retires as a bubble
  assign bubble_c = ~valid_in | flush | stall | is_multu_c;

  assign ctrl_in_c = '{mem_read:   memRead,
                       mem_write:  memWrite,
                       branch:     branch,
                       reg_write:  regWriteIn,
                       mem_to_reg: MemToRegIn};

  mult_unit #(
    .MULT_ITER (MULT_ITER)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start_c),
    .abort   (flush),
    .mcand   (rs_data),
    .mplier  (rt_data),
    .idle_c  (mult_idle_c),
    .busy_c  (mult_busy_c),
    .done_c  (mult_done_c),
    .product (mult_product)
  );

  always_comb begin
    alu_res_c = '0;
    case (aluCtrl)
      ALU_AND:  alu_res_c = rs_data & opb_c;
      ALU_OR:   alu_res_c = rs_data | opb_c;
      ALU_ADD:  alu_res_c = rs_data + opb_c;
      ALU_SUB:  alu_res_c = rs_data - opb_c;
      ALU_SLT:  alu_res_c = XLEN'($signed(rs_data) < $signed(opb_c));
      ALU_NOR:  alu_res_c = ~(rs_data | opb_c);
      ALU_MFHI: alu_res_c = hi_q;
      ALU_MFLO: alu_res_c = lo_q;
      default:  alu_res_c = '0;
    endcase
  end

  // HI/LO commit as the MULTU leaves EX, so a flush in DONE still discards it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mult_done_c && !flush) begin
      hi_q <= mult_product[2*XLEN-1:XLEN];
      lo_q <= mult_product[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUresult       <= '0;
      zero            <= 1'b0;
      Rt_data         <= '0;
      branch_out      <= '0;
      Destination_out <= '0;
      ctrl_q          <= '0;
    end else begin
      ALUresult       <= alu_res_c;
      zero            <= (alu_res_c == '0);
      Rt_data         <= rt_data;
      branch_out      <= pc_plus4 + {imm[XLEN-3:0], 2'b00};
      Destination_out <= RegDst ? rd_addr : rt_addr;
      if (bubble_c) begin
        ctrl_q <= '0;
      end else begin
        ctrl_q <= ctrl_in_c;
      end
    end
  end

  assign memReadOut  = ctrl_q.mem_read;
  assign memWriteOut = ctrl_q.mem_write;
  assign branchOut   = ctrl_q.branch;
  assign regWriteOut = ctrl_q.reg_write;
  assign MemToRegOut = ctrl_q.mem_to_reg;

endmodule
